// File: rtl/motion_frame_sequencer_pkg.sv
// Shared constants and enums for the motion-detection frame sequencer.
// Defaults describe a full 768x576 BGR frame.
package motion_detect_pkg;

    localparam int unsigned WIDTH        = 32'd768;
    localparam int unsigned HEIGHT       = 32'd576;
    localparam int unsigned PIXEL_W      = 32'd24;
    localparam int unsigned FRAME_PIXELS = WIDTH * HEIGHT;
    localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS + 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef enum logic {
        BG = 1'b0,
        FR = 1'b1
    } pix_phase_t;

endpackage

// File: rtl/motion_frame_sequencer_if.sv
// Upstream pixel stream, the three input-FIFO write ports and the observed output FIFO read side.
interface motion_frame_sequencer_if;
    import motion_detect_pkg::*;

    logic               in_valid;
    logic [PIXEL_W-1:0] in_din;
    logic               in_ready;
    logic               bg_full;
    logic               bg_wr_en;
    logic [PIXEL_W-1:0] bg_din;
    logic               fr_full;
    logic               fr_wr_en;
    logic [PIXEL_W-1:0] fr_din;
    logic               highlight_fr_full;
    logic               highlight_fr_wr_en;
    logic [PIXEL_W-1:0] highlight_fr_din;
    logic               out_rd_en;
    logic               out_empty;

    modport slave (
        input  in_valid, in_din, bg_full, fr_full, highlight_fr_full, out_rd_en, out_empty,
        output in_ready, bg_wr_en, bg_din, fr_wr_en, fr_din, highlight_fr_wr_en, highlight_fr_din
    );

    modport master (
        output in_valid, in_din, bg_full, fr_full, highlight_fr_full, out_rd_en, out_empty,
        input  in_ready, bg_wr_en, bg_din, fr_wr_en, fr_din, highlight_fr_wr_en, highlight_fr_din
    );

endinterface

// File: rtl/motion_frame_sequencer_counter.sv
// Saturating per-frame pixel counter; last flags the final pixel of the frame.
module motion_pixel_counter #(
    parameter int unsigned FRAME_N  = motion_detect_pkg::FRAME_PIXELS,
    parameter int unsigned CNT_BITS = motion_detect_pkg::CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count,
    output logic                last
);

    localparam logic [CNT_BITS-1:0] MAX_C  = CNT_BITS'(FRAME_N);
    localparam logic [CNT_BITS-1:0] LAST_C = CNT_BITS'(FRAME_N - 32'd1);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    // Next count: clear wins, increments stop at a full frame.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_C)) begin
            count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_C);

endmodule

// File: rtl/motion_frame_sequencer.sv
// Sequences one frame: splits the interleaved bg/fr stream into three FIFOs
// in lockstep and reports completion once every output pixel has been read.
module motion_frame_sequencer #(
    parameter int unsigned WIDTH  = motion_detect_pkg::WIDTH,
    parameter int unsigned HEIGHT = motion_detect_pkg::HEIGHT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    motion_frame_sequencer_if.slave bus
);
    import motion_detect_pkg::*;

    localparam int unsigned FRAME_N  = WIDTH * HEIGHT;
    localparam int unsigned CNT_BITS = $clog2(FRAME_N + 32'd1);
    localparam logic [CNT_BITS-1:0] FULL_C = CNT_BITS'(FRAME_N);

    seq_state_t state_q;
    pix_phase_t phase_q;
    logic       busy_q;
    logic       done_q;

    logic                in_ready_s, xfer_s, bg_wr_s, fr_wr_s;
    logic                start_s, rd_cnt_s, in_last_s, out_last_s;
    logic [CNT_BITS-1:0] in_cnt_s, out_cnt_s;

    // Acceptance depends only on the FIFOs the current phase will write.
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_q == ROUTE) && (in_cnt_s != FULL_C)) begin
            if (phase_q == BG) begin
                in_ready_s = !bus.bg_full;
            end else begin
                in_ready_s = !bus.fr_full && !bus.highlight_fr_full;
            end
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign xfer_s   = bus.in_valid && in_ready_s;
    assign bg_wr_s  = xfer_s && (phase_q == BG);
    assign fr_wr_s  = xfer_s && (phase_q == FR);
    assign start_s  = (state_q == IDLE) && start;
    assign rd_cnt_s = bus.out_rd_en && !bus.out_empty && (out_cnt_s != FULL_C)
                      && ((state_q == ROUTE) || (state_q == DRAIN));

    assign bus.in_ready           = in_ready_s;
    assign bus.bg_wr_en           = bg_wr_s;
    assign bus.fr_wr_en           = fr_wr_s;
    assign bus.highlight_fr_wr_en = fr_wr_s;
    assign bus.bg_din             = bg_wr_s ? bus.in_din : '0;
    assign bus.fr_din             = fr_wr_s ? bus.in_din : '0;
    assign bus.highlight_fr_din   = fr_wr_s ? bus.in_din : '0;

    motion_pixel_counter #(.FRAME_N(FRAME_N), .CNT_BITS(CNT_BITS)) u_in_cnt (
        .clock(clock), .reset(reset), .clear(start_s), .inc(fr_wr_s),
        .count(in_cnt_s), .last(in_last_s)
    );

    motion_pixel_counter #(.FRAME_N(FRAME_N), .CNT_BITS(CNT_BITS)) u_out_cnt (
        .clock(clock), .reset(reset), .clear(start_s), .inc(rd_cnt_s),
        .count(out_cnt_s), .last(out_last_s)
    );

    // Frame FSM; a completed read count ends the frame even from ROUTE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= BG;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ROUTE;
                        phase_q <= BG;
                        busy_q  <= 1'b1;
                    end
                end
                ROUTE: begin
                    if (xfer_s) begin
                        phase_q <= (phase_q == BG) ? FR : BG;
                    end
                    if (rd_cnt_s && out_last_s) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (fr_wr_s && in_last_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_cnt_s && out_last_s) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= BG;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_motion_frame_sequencer.sv
// Randomised and directed checks of motion_frame_sequencer on a 4x2 frame
// against a transfer/read counting reference model.
module tb_motion_frame_sequencer;
    import motion_detect_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clock = 1'b0;
    logic reset, start;
    logic busy, done;

    motion_frame_sequencer_if bus();

    motion_frame_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is active from an accepted start until the N-th counted read.
    bit m_active, m_done;
    int m_xfers, m_reads, m_frame;
    int dut_bg_w, dut_fr_w, dut_hl_w, dut_done_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] word_of(input int k, input int frame);
        logic [23:0] w;
        w = ((k % 2) == 1) ? 24'hF00000 : 24'h000000;
        w = w | 24'(((k / 2) & 32'hF) << 4) | 24'((frame & 32'hFF) << 8);
        return w;
    endfunction

    task automatic step(input bit st, input bit vld, input bit bf, input bit ff, input bit hf,
                        input bit rd, input bit emp, input bit rn);
        bit          exp_ready, exp_bg, exp_fr, xfer, rd_cnt, fin;
        logic [23:0] w;
        @(negedge clock);
        reset                 = rn;
        start                 = st;
        bus.in_valid          = vld;
        bus.bg_full           = bf;
        bus.fr_full           = ff;
        bus.highlight_fr_full = hf;
        bus.out_rd_en         = rd;
        bus.out_empty         = emp;
        w                     = word_of(m_xfers, m_frame);
        bus.in_din            = w;
        #1;
        exp_ready = m_active && (m_xfers < 2 * N) &&
                    (((m_xfers % 2) == 0) ? !bf : (!ff && !hf));
        xfer   = vld && exp_ready;
        exp_bg = xfer && ((m_xfers % 2) == 0);
        exp_fr = xfer && ((m_xfers % 2) == 1);
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check_eq("bg_wr_en", 32'(bus.bg_wr_en), 32'(exp_bg));
        check_eq("fr_wr_en", 32'(bus.fr_wr_en), 32'(exp_fr));
        check_eq("hl_wr_en", 32'(bus.highlight_fr_wr_en), 32'(exp_fr));
        check_eq("bg_din", 32'(bus.bg_din), exp_bg ? 32'(w) : 32'd0);
        check_eq("fr_din", 32'(bus.fr_din), exp_fr ? 32'(w) : 32'd0);
        check_eq("hl_din", 32'(bus.highlight_fr_din), exp_fr ? 32'(w) : 32'd0);
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("done", 32'(done), 32'(m_done));
        dut_bg_w   += (bus.bg_wr_en === 1'b1) ? 1 : 0;
        dut_fr_w   += (bus.fr_wr_en === 1'b1) ? 1 : 0;
        dut_hl_w   += (bus.highlight_fr_wr_en === 1'b1) ? 1 : 0;
        dut_done_n += (done === 1'b1) ? 1 : 0;
        @(posedge clock);
        if (!rn) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_xfers  = 0;
            m_reads  = 0;
        end else begin
            rd_cnt = m_active && rd && !emp;
            fin    = rd_cnt && (m_reads == N - 1);
            if (xfer)   m_xfers++;
            if (rd_cnt) m_reads++;
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active && st) begin
                m_active   = 1'b1;
                m_xfers    = 0;
                m_reads    = 0;
                m_frame++;
                dut_bg_w   = 0;
                dut_fr_w   = 0;
                dut_hl_w   = 0;
                dut_done_n = 0;
            end
            if (fin) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic read(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_bg_writes"}, 32'(dut_bg_w), 32'(N));
        check_eq({tag, "_fr_writes"}, 32'(dut_fr_w), 32'(N));
        check_eq({tag, "_hl_writes"}, 32'(dut_hl_w), 32'(N));
        check_eq({tag, "_done_pulses"}, 32'(dut_done_n), 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_din = 24'h0;
        bus.bg_full = 1'b0; bus.fr_full = 1'b0; bus.highlight_fr_full = 1'b0;
        bus.out_rd_en = 1'b0; bus.out_empty = 1'b1;
        m_active = 1'b0; m_done = 1'b0; m_xfers = 0; m_reads = 0; m_frame = 0;
        dut_bg_w = 0; dut_fr_w = 0; dut_hl_w = 0; dut_done_n = 0;
        repeat (2) @(posedge clock);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0, 0);

        // Reads and stray valid while idle must do nothing.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0, 1);

        // Nominal frame with an ignored start in the middle of routing.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 2 * N; k++) step(k == 5, 1, 0, 0, 0, 0, 0, 1);
        idle(2);
        read(N);
        idle(2);
        check_frame("nominal");

        // Highlight backpressure on FR, bg stall on BG, reads against an empty FIFO.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        push(1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 0, 0, 1);
        push(1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 40 && m_xfers < 2 * N; i++) push(1);
        check_eq("stall_all_words", 32'(dut_bg_w + dut_fr_w), 32'(2 * N));
        read(N);
        idle(2);
        check_frame("stall");

        // Reset after three pixels abandons the frame; a fresh frame then runs clean.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        push(6);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        push(2 * N);
        read(N);
        idle(2);
        check_frame("after_reset");

        // Randomised traffic, including early reads, starts in DONE and FIFO full storms.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
